// File: rtl/lif_tm_scheduler.sv
// Timestep scheduler for a bank of time-multiplexed LIF neurons.
// One shared leak/integrate/fire/refractory datapath, one neuron per cycle.
module lif_tm_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int W         = 8,
  parameter int IDX_W     = 3,
  parameter int REFRAC    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_i,
  input  logic [N_NEURONS*W-1:0] current_i,
  input  logic                   cfg_we_i,
  input  logic                   cfg_sel_i,
  input  logic [W-1:0]           cfg_data_i,
  output logic                   cfg_ready_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [N_NEURONS-1:0]   spike_o,
  output logic                   spike_valid_o,
  output logic                   tick_drop_o
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state, state_nx;
  logic   accept;

  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         thr;
  logic [2:0]           leak;
  logic [W-1:0]         v   [N_NEURONS];
  logic [2:0]           r   [N_NEURONS];
  logic [W-1:0]         cur [N_NEURONS];
  logic [N_NEURONS-1:0] acc;
  logic [N_NEURONS-1:0] acc_nx;

  logic [W-1:0] v_cur;
  logic [W:0]   leak_term;
  logic [W:0]   half_cur;
  logic [W:0]   sum;
  logic [W-1:0] vn;
  logic         refr;
  logic         fire;
  logic         last;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick_i) begin
          accept   = 1'b1;
          state_nx = SWEEP;
        end
      end
      SWEEP: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (tick_i) begin
          accept   = 1'b1;
          state_nx = SWEEP;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // W+1 bits: max V plus half current cannot wrap before saturation
  always_comb begin
    v_cur     = v[idx];
    leak_term = (leak == 3'd0) ? '0 : {1'b0, v_cur >> leak};
    half_cur  = {1'b0, cur[idx] >> 1};
    sum       = {1'b0, v_cur} - leak_term + half_cur;
    vn        = sum[W] ? '1 : sum[W-1:0];
    refr      = (r[idx] != 3'd0);
    fire      = !refr && (vn >= thr);
    last      = (idx == IDX_W'(N_NEURONS - 1));
    acc_nx    = acc | (N_NEURONS'(fire) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      thr         <= W'(127);
      leak        <= 3'd3;
      acc         <= '0;
      spike_o     <= '0;
      spike_valid_o <= 1'b0;
      tick_drop_o <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i]   <= '0;
        r[i]   <= '0;
        cur[i] <= '0;
      end
    end else begin
      tick_drop_o   <= tick_i && (state == SWEEP);
      spike_valid_o <= 1'b0;
      if (cfg_we_i && state == IDLE) begin
        if (cfg_sel_i) leak <= cfg_data_i[2:0];
        else           thr  <= cfg_data_i;
      end
      if (accept) begin
        idx <= '0;
        acc <= '0;
        for (int i = 0; i < N_NEURONS; i++)
          cur[i] <= current_i[i*W +: W];
      end else if (state == SWEEP) begin
        idx <= idx + 1'b1;
        acc <= acc_nx;
        if (refr) begin
          v[idx] <= '0;
          r[idx] <= r[idx] - 3'd1;
        end else if (fire) begin
          v[idx] <= '0;
          r[idx] <= 3'(REFRAC);
        end else begin
          v[idx] <= vn;
        end
        if (last) begin
          spike_o       <= acc_nx;
          spike_valid_o <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign idx_o       = idx;

endmodule

// File: tb/tb_lif_tm_scheduler.sv
// Self-checking bench for lif_tm_scheduler: vector table, hand sequences,
// and randomized timesteps against a per-neuron arithmetic model.
module tb_lif_tm_scheduler;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int RF = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick_i = 1'b0;
  logic [N*W-1:0] current_i = '0;
  logic           cfg_we_i = 1'b0;
  logic           cfg_sel_i = 1'b0;
  logic [W-1:0]   cfg_data_i = '0;
  logic           cfg_ready_o;
  logic           busy_o;
  logic [2:0]     idx_o;
  logic [N-1:0]   spike_o;
  logic           spike_valid_o;
  logic           tick_drop_o;

  lif_tm_scheduler #(
    .N_NEURONS(N), .W(W), .IDX_W(3), .REFRAC(RF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i),
    .current_i(current_i), .cfg_we_i(cfg_we_i),
    .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .busy_o(busy_o),
    .idx_o(idx_o), .spike_o(spike_o),
    .spike_valid_o(spike_valid_o), .tick_drop_o(tick_drop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int mv [N];
  int mr [N];
  int mthr;
  int mleak;

  typedef struct {
    bit             rst;
    logic [W-1:0]   thr;
    logic [2:0]     leak;
    logic [N*W-1:0] cur;
    logic [N-1:0]   exp;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mr[i] = 0;
    end
    mthr  = 127;
    mleak = 3;
  endtask

  task automatic model_step(input logic [N*W-1:0] cur,
                            output logic [N-1:0] s);
    int lt, vn, ii;
    s = '0;
    for (int i = 0; i < N; i++) begin
      ii = int'(cur[i*W +: W]);
      if (mr[i] > 0) begin
        mv[i] = 0;
        mr[i] = mr[i] - 1;
      end else begin
        lt = (mleak == 0) ? 0 : (mv[i] >> mleak);
        vn = mv[i] - lt + ii / 2;
        if (vn > 255) vn = 255;
        if (vn >= mthr) begin
          s[i]  = 1'b1;
          mv[i] = 0;
          mr[i] = RF;
        end else begin
          mv[i] = vn;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tick_i = 1'b0;
    cfg_we_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) chk("idle_timeout", 32'(busy_o), 0);
  endtask

  task automatic cfg_write(input bit sel, input logic [W-1:0] d);
    bit rdy;
    wait_idle();
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_data_i = d;
    rdy = cfg_ready_o;
    step();
    cfg_we_i = 1'b0;
    if (rdy) begin
      if (sel) mleak = int'(d[2:0]);
      else     mthr  = int'(d);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!spike_valid_o && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) chk({name, "_timeout"}, 32'(spike_valid_o), 1);
  endtask

  // Starts from IDLE or DONE; returns in the DONE cycle.
  task automatic run_tick(input logic [N*W-1:0] cur,
                          output logic [N-1:0] exp);
    current_i = cur;
    tick_i    = 1'b1;
    step();
    tick_i = 1'b0;
    model_step(cur, exp);
    wait_valid("tick");
  endtask

  logic [N-1:0] e;

  initial begin
    // table: hand-derived spike vectors
    vecs.push_back('{1, 127, 3, 64'd100, 8'h00});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h00});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h01});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h00});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h00});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h00});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h00});
    vecs.push_back('{0, 127, 3, 64'd100, 8'h01});
    vecs.push_back('{1, 255, 0, {N*W{1'b1}}, 8'h00});
    vecs.push_back('{0, 255, 0, {N*W{1'b1}}, 8'h00});
    vecs.push_back('{0, 255, 0, {N*W{1'b1}}, 8'hFF});
    vecs.push_back('{0, 255, 0, {N*W{1'b1}}, 8'h00});
    vecs.push_back('{1, 0, 3, 64'd0, 8'hFF});
    vecs.push_back('{0, 0, 3, 64'd0, 8'h00});
    vecs.push_back('{0, 0, 3, 64'd0, 8'h00});
    vecs.push_back('{0, 0, 3, 64'd0, 8'hFF});
    vecs.push_back('{1, 10, 3, 64'd30 << 16, 8'h04});

    do_reset();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ready", 32'(cfg_ready_o), 1);
    chk("rst_spike", 32'(spike_o), 0);
    chk("rst_valid", 32'(spike_valid_o), 0);
    chk("rst_drop", 32'(tick_drop_o), 0);
    chk("rst_idx", 32'(idx_o), 0);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      cfg_write(1'b0, vecs[k].thr);
      cfg_write(1'b1, W'(vecs[k].leak));
      run_tick(vecs[k].cur, e);
      chk($sformatf("vec%0d", k), 32'(spike_o), 32'(vecs[k].exp));
      chk($sformatf("vec%0d_model", k), 32'(spike_o), 32'(e));
    end

    // latency and back-to-back from DONE
    do_reset();
    current_i = '0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    model_step('0, e);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) chk($sformatf("lat_idx_c%0d", c), 32'(idx_o), 32'(c - 1));
      chk($sformatf("lat_valid_c%0d", c), 32'(spike_valid_o), 32'(c == 9));
      chk($sformatf("lat_busy_c%0d", c), 32'(busy_o), 1);
      if (c == 9) tick_i = 1'b1;
      step();
    end
    tick_i = 1'b0;
    model_step('0, e);
    chk("b2b_busy", 32'(busy_o), 1);
    chk("b2b_idx", 32'(idx_o), 0);
    chk("b2b_valid", 32'(spike_valid_o), 0);
    wait_valid("b2b");
    chk("b2b_spike", 32'(spike_o), 32'(e));

    // dropped tick during sweep
    wait_idle();
    current_i = 64'd100;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    model_step(64'd100, e);
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("drop_c%0d", c), 32'(tick_drop_o), 32'(c == 5));
      chk($sformatf("drop_valid_c%0d", c), 32'(spike_valid_o),
          32'(c == 9));
      chk($sformatf("drop_busy_c%0d", c), 32'(busy_o), 32'(c <= 9));
      tick_i = (c == 4);
      step();
    end
    tick_i = 1'b0;
    chk("drop_spike", 32'(spike_o), 32'(e));

    // config write during sweep is discarded
    do_reset();
    current_i = 64'd30 << 16;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    model_step(64'd30 << 16, e);
    step();
    chk("cfg_busy_ready", 32'(cfg_ready_o), 0);
    cfg_we_i = 1'b1;
    cfg_sel_i = 1'b0;
    cfg_data_i = 8'd10;
    step();
    cfg_we_i = 1'b0;
    wait_valid("cfg_sweep");
    chk("cfg_ignored", 32'(spike_o), 0);
    chk("cfg_ignored_model", 32'(spike_o), 32'(e));
    cfg_write(1'b0, 8'd10);
    run_tick(64'd30 << 16, e);
    chk("cfg_accepted", 32'(spike_o), 32'h04);
    chk("cfg_accepted_model", 32'(spike_o), 32'(e));

    // reset mid-sweep, then scenario 1 reproduces
    do_reset();
    for (int t = 0; t < 3; t++) run_tick(64'd100, e);
    chk("pre_rst_spike", 32'(spike_o), 32'h01);
    wait_idle();
    current_i = 64'd100;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_spike", 32'(spike_o), 0);
    chk("mid_rst_valid", 32'(spike_valid_o), 0);
    chk("mid_rst_idx", 32'(idx_o), 0);
    chk("mid_rst_ready", 32'(cfg_ready_o), 1);
    step();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("post_rst_valid%0d", c), 32'(spike_valid_o), 0);
      step();
    end
    run_tick(64'd100, e);
    chk("rerun1", 32'(spike_o), 0);
    run_tick(64'd100, e);
    chk("rerun2", 32'(spike_o), 0);
    run_tick(64'd100, e);
    chk("rerun3", 32'(spike_o), 32'h01);
    chk("rerun3_model", 32'(spike_o), 32'(e));

    // randomized timesteps against the model
    do_reset();
    for (int k = 0; k < 60; k++) begin
      logic [N*W-1:0] cur;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          cfg_write(1'b0, W'($urandom_range(0, 255)));
        else
          cfg_write(1'b1, W'($urandom_range(0, 7)));
      end else if ($urandom_range(0, 1) == 0) begin
        wait_idle();
      end
      cur = {$urandom, $urandom};
      run_tick(cur, e);
      chk($sformatf("rand%0d", k), 32'(spike_o), 32'(e));
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
